// File: rtl/sum_result_sink.sv
// -----------------------------------------------------------------------------
// sum_result_sink
//   Receiving end of the registered 4-bit adder result interface. Result words
//   (5-bit sum + overflow flag) arrive over a valid/ready handshake and are
//   buffered in a small FIFO. A control FSM drains N_WORDS words per group into
//   a saturating accumulator. It also counts overflow flags and flags any word
//   whose overflow bit disagrees with its sum MSB. The finished group summary is
//   offered downstream on a second valid/ready handshake.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   N_WORDS  result words per group (>= 1)
//   ACC_W    accumulator width (>= 5), saturates at 2^ACC_W-1
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   in_valid       result word present
//   in_ready       sink can accept a word (registered FIFO not full)
//   in_sum         adder sum, 0..30
//   in_overflow    adder carry-out flag
//   out_valid      group summary valid
//   out_ready      downstream accepts the summary
//   out_total      saturating sum of the group's in_sum values
//   out_ovf_cnt    number of words in the group with in_overflow = 1
//   out_sat        accumulator clamped at least once during the group
//   out_err        at least one word had in_overflow != in_sum[4]
// -----------------------------------------------------------------------------
module sum_result_sink #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned N_WORDS = 4,
  parameter int unsigned ACC_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [4:0]                         in_sum,
  input  logic                               in_overflow,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_W-1:0]                   out_total,
  output logic [$clog2(N_WORDS+1)-1:0]       out_ovf_cnt,
  output logic                               out_sat,
  output logic                               out_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(N_WORDS + 1);

  typedef logic [AW:0] ptr_t;

  typedef struct packed {
    logic [4:0] sum;
    logic       ovf;
  } word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  word_t mem [DEPTH];
  ptr_t  wr_ptr, rd_ptr;
  logic  full, empty;
  logic  push, pop;
  word_t rd_word;

  // The extra MSB on each pointer separates "wrapped once" (full) from
  // "caught up" (empty) when the index bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  // Refused when full even if a pop happens this cycle: no bypass path.
  assign push     = in_valid && !full;
  assign rd_word  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage array has no reset; entries are only read after being
  // written, and the reset-cleared pointers guarantee that.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{sum: in_sum, ovf: in_overflow};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and accumulator
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic [ACC_W:0]   sum_ext;
  logic             load_out;
  logic             clr_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every variable gets a default before the case statement, so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    err_d    = err_q;
    pop      = 1'b0;
    load_out = 1'b0;
    clr_out  = 1'b0;
    // One extra bit catches the carry that signals a clamp.
    sum_ext  = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, rd_word.sum};

    unique case (state_q)
      IDLE: begin
        acc_d = '0;
        ovf_d = '0;
        cnt_d = '0;
        sat_d = 1'b0;
        err_d = 1'b0;
        if (!empty) state_d = ACCUM;
      end

      ACCUM: begin
        // An empty FIFO is a stall: all group state simply holds.
        if (!empty) begin
          pop = 1'b1;
          if (sum_ext[ACC_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
          end
          ovf_d = ovf_q + CW'(rd_word.ovf);
          if (rd_word.ovf != rd_word.sum[4]) err_d = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_WORDS - 1)) begin
            state_d  = DONE;
            load_out = 1'b1;
          end
        end
      end

      DONE: begin
        // out_valid is high for exactly the DONE state.
        if (out_ready) begin
          state_d = IDLE;
          clr_out = 1'b1;
          acc_d   = '0;
          ovf_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered summary outputs: loaded with the post-pop values on the final
  // pop of a group, held through backpressure, zeroed on handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_total   <= '0;
      out_ovf_cnt <= '0;
      out_sat     <= 1'b0;
      out_err     <= 1'b0;
    end else if (load_out) begin
      out_valid   <= 1'b1;
      out_total   <= acc_d;
      out_ovf_cnt <= ovf_d;
      out_sat     <= sat_d;
      out_err     <= err_d;
    end else if (clr_out) begin
      out_valid   <= 1'b0;
      out_total   <= '0;
      out_ovf_cnt <= '0;
      out_sat     <= 1'b0;
      out_err     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_result_sink.sv
`timescale 1ns/1ps
module tb_sum_result_sink;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-parameter instance (ACC_W = 8)
  logic       in_valid, in_ready, in_overflow, out_valid, out_ready, out_sat, out_err;
  logic [4:0] in_sum;
  logic [7:0] out_total;
  logic [2:0] out_ovf_cnt;

  // Saturation instance (ACC_W = 6)
  logic       in_valid6, in_ready6, in_overflow6, out_valid6, out_ready6, out_sat6, out_err6;
  logic [4:0] in_sum6;
  logic [5:0] out_total6;
  logic [2:0] out_ovf_cnt6;

  sum_result_sink #(.DEPTH(4), .N_WORDS(4), .ACC_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
    .out_ovf_cnt(out_ovf_cnt), .out_sat(out_sat), .out_err(out_err)
  );

  sum_result_sink #(.DEPTH(4), .N_WORDS(4), .ACC_W(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_sum(in_sum6), .in_overflow(in_overflow6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_total(out_total6),
    .out_ovf_cnt(out_ovf_cnt6), .out_sat(out_sat6), .out_err(out_err6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int push_cyc = 0;

  // Offer one word and hold it until captured (bounded).
  task automatic push(input logic [4:0] s, input logic f);
    int n = 0;
    in_valid = 1'b1; in_sum = s; in_overflow = f;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL push_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
    end else begin
      @(posedge clk); #1;
      push_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (!out_valid) begin
      n_bad++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1 within %0d cycles", out_valid, budget);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL accept_drop: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_total !== 8'd0 ||
          out_ovf_cnt !== 3'd0 || out_sat !== 1'b0 || out_err !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: ready=%0b valid=%0b total=%0d ovf=%0d sat=%0b err=%0b required 1 0 0 0 0 0",
                 k, in_ready, out_valid, out_total, out_ovf_cnt, out_sat, out_err);
      end
      n_cmp++;
      if (in_ready6 !== 1'b1 || out_valid6 !== 1'b0 || out_total6 !== 6'd0) begin
        n_bad++;
        $display("FAIL reset_idle6[%0d]: ready=%0b valid=%0b total=%0d required 1 0 0",
                 k, in_ready6, out_valid6, out_total6);
      end
      // Second pass: out_ready alone must change nothing.
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_nominal();
    int first;
    push(5'b11110, 1'b1);
    first = push_cyc;
    push(5'b00110, 1'b0);
    push(5'b11000, 1'b1);
    push(5'b10010, 1'b1);
    wait_valid(20);
    // Capture edge + IDLE->ACCUM edge + 4 pop edges = 6 edges; the 6th edge
    // is 5 edges after the capture edge.
    n_cmp++;
    if (cyc - first !== 5) begin
      n_bad++; $display("FAIL nominal_latency: edges after capture=%0d required 5", cyc - first);
    end
    n_cmp++;
    if (out_total !== 8'd78 || out_ovf_cnt !== 3'd3 || out_sat !== 1'b0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL nominal_summary: total=%0d ovf=%0d sat=%0b err=%0b required 78 3 0 0",
               out_total, out_ovf_cnt, out_sat, out_err);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(5'b10100, 1'b1);
    push(5'b01010, 1'b0);
    push(5'b10100, 1'b1);
    push(5'b01010, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_full: in_ready=%0b required 0", in_ready);
    end
    // Fifth word held while full; summary must stay put.
    in_valid = 1'b1; in_sum = 5'b00001; in_overflow = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_total !== 8'd78 ||
          out_ovf_cnt !== 3'd3 || out_sat !== 1'b0 || out_err !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_stable[%0d]: ready=%0b valid=%0b total=%0d ovf=%0d sat=%0b err=%0b required 0 1 78 3 0 0",
                 k, in_ready, out_valid, out_total, out_ovf_cnt, out_sat, out_err);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_total !== 8'd0 || out_ovf_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL bp_release: valid=%0b total=%0d ovf=%0d required 0 0 0", out_valid, out_total, out_ovf_cnt);
    end
    push(5'b00001, 1'b0);
    wait_valid(20);
    n_cmp++;
    if (out_total !== 8'd60 || out_ovf_cnt !== 3'd2 || out_sat !== 1'b0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_group2: total=%0d ovf=%0d sat=%0b err=%0b required 60 2 0 0",
               out_total, out_ovf_cnt, out_sat, out_err);
    end
    accept();
    // The held word opens the next group.
    push(5'b00001, 1'b0);
    push(5'b00001, 1'b0);
    push(5'b00001, 1'b0);
    wait_valid(20);
    n_cmp++;
    if (out_total !== 8'd4 || out_ovf_cnt !== 3'd0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_group3: total=%0d ovf=%0d err=%0b required 4 0 0", out_total, out_ovf_cnt, out_err);
    end
    accept();
  endtask

  task automatic test_saturation();
    int n = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid6 = 1'b1; in_sum6 = 5'b11110; in_overflow6 = 1'b1;
      n_cmp++;
      if (in_ready6 !== 1'b1) begin
        n_bad++; $display("FAIL sat_ready[%0d]: in_ready=%0b required 1", k, in_ready6);
      end
      @(posedge clk); #1;
    end
    in_valid6 = 1'b0;
    while (!out_valid6 && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (out_valid6 !== 1'b1 || out_total6 !== 6'd63 || out_sat6 !== 1'b1 ||
        out_ovf_cnt6 !== 3'd4 || out_err6 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_summary: valid=%0b total=%0d sat=%0b ovf=%0d err=%0b required 1 63 1 4 0",
               out_valid6, out_total6, out_sat6, out_ovf_cnt6, out_err6);
    end
    out_ready6 = 1'b1;
    @(posedge clk); #1;
    out_ready6 = 1'b0;
    n_cmp++;
    if (out_valid6 !== 1'b0 || out_total6 !== 6'd0 || out_sat6 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_release: valid=%0b total=%0d sat=%0b required 0 0 0", out_valid6, out_total6, out_sat6);
    end
  endtask

  task automatic test_flag_stall();
    push(5'b00011, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_no_valid: out_valid=%0b required 0", out_valid);
    end
    push(5'b00011, 1'b0);
    push(5'b00000, 1'b0);
    push(5'b00001, 1'b0);
    wait_valid(20);
    n_cmp++;
    if (out_err !== 1'b1 || out_total !== 8'd7 || out_ovf_cnt !== 3'd1 || out_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_summary: err=%0b total=%0d ovf=%0d sat=%0b required 1 7 1 0",
               out_err, out_total, out_ovf_cnt, out_sat);
    end
  endtask

  task automatic test_async_reset();
    // Summary still presented from the previous task; reset between edges.
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_total !== 8'd0 || out_ovf_cnt !== 3'd0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_done: valid=%0b total=%0d ovf=%0d err=%0b ready=%0b required 0 0 0 0 1",
               out_valid, out_total, out_ovf_cnt, out_err, in_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    // Four words captured; two popped by the time the last push returns.
    push(5'b11110, 1'b1);
    push(5'b11110, 1'b1);
    push(5'b11110, 1'b1);
    push(5'b11110, 1'b1);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_total !== 8'd0) begin
      n_bad++;
      $display("FAIL areset_mid: valid=%0b ready=%0b total=%0d required 0 1 0", out_valid, in_ready, out_total);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) push(5'b00001, 1'b0);
    wait_valid(20);
    n_cmp++;
    if (out_total !== 8'd4 || out_ovf_cnt !== 3'd0 || out_sat !== 1'b0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_fresh: total=%0d ovf=%0d sat=%0b err=%0b required 4 0 0 0",
               out_total, out_ovf_cnt, out_sat, out_err);
    end
    accept();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sum = '0; in_overflow = 1'b0; out_ready = 1'b0;
    in_valid6 = 1'b0; in_sum6 = '0; in_overflow6 = 1'b0; out_ready6 = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_saturation();
    test_flag_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
